// File: rtl/line_burst_responder_if.sv
// rtl/line_burst_responder_if.sv - line-side and memory-side signal bundle for line_burst_responder
//
// Purpose: groups the initiator line port, the physical-memory burst port and
// the statistics outputs into one bundle.
// Modports:
//   slave  - responder view (line_burst_responder): takes line requests and
//            memory responses, drives line response, burst requests, counters.
//   master - environment view: initiator plus memory, the mirror of slave.
// Signals:
//   line_read/line_write/line_address/line_wdata  initiator request, held until line_resp
//   line_resp/line_rdata                          one-cycle completion and assembled read line
//   mem_read/mem_write/mem_address/mem_wdata      burst request and current write beat
//   mem_rdata/mem_resp                            per-beat memory acknowledge and read data
//   rd_count/wr_count                             completed-transaction counters
interface line_burst_responder_if #(
    parameter int s_offset = 5,
    parameter int s_mask   = 2**s_offset,
    parameter int s_line   = 8*s_mask,
    parameter int s_beat   = 64
);
    logic              line_read;
    logic              line_write;
    logic [31:0]       line_address;
    logic [s_line-1:0] line_wdata;
    logic              line_resp;
    logic [s_line-1:0] line_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_address;
    logic [s_beat-1:0] mem_wdata;
    logic [s_beat-1:0] mem_rdata;
    logic              mem_resp;
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;

    modport slave (
        input  line_read, line_write, line_address, line_wdata, mem_rdata, mem_resp,
        output line_resp, line_rdata, mem_read, mem_write, mem_address, mem_wdata,
               rd_count, wr_count
    );

    modport master (
        output line_read, line_write, line_address, line_wdata, mem_rdata, mem_resp,
        input  line_resp, line_rdata, mem_read, mem_write, mem_address, mem_wdata,
               rd_count, wr_count
    );
endinterface

// File: rtl/line_burst_responder.sv
// rtl/line_burst_responder.sv - converts whole-line read/write requests into fixed-length memory bursts
//
// Purpose: accepts one held line request at a time, runs an s_burst-beat
// burst of s_beat-bit beats on the memory port at the line-aligned address,
// then pulses line_resp for one cycle. Write wins when both requests are high.
// Ports:
//   clk  - clock, all logic on the rising edge
//   rst  - synchronous active-high reset; aborts any burst without a response
//   bus  - line_burst_responder_if.slave (line port, memory port, counters)
// Configuration macro: LBR_STATS_EN builds the rd_count/wr_count transaction
// counters; when undefined both outputs are tied to zero.
module line_burst_responder #(
    parameter int s_offset = 5,
    parameter int s_mask   = 2**s_offset,
    parameter int s_line   = 8*s_mask,
    parameter int s_beat   = 64,
    parameter int s_burst  = s_line/s_beat
) (
    input  logic                       clk,
    input  logic                       rst,
    line_burst_responder_if.slave      bus
);
    localparam int CW = 2;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              last_beat;
    logic [s_line-1:0] wdata_q;
    logic              line_resp_q;
    logic [s_line-1:0] line_rdata_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [31:0]       mem_address_q;
    logic [s_beat-1:0] mem_wdata_q;

    assign cnt_d     = cnt_q + 1'b1;
    assign last_beat = (cnt_q == CW'(s_burst-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wdata_q       <= '0;
            line_resp_q   <= 1'b0;
            line_rdata_q  <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
        end else begin
            line_resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.line_write) begin
                        wdata_q       <= bus.line_wdata;
                        mem_address_q <= {bus.line_address[31:s_offset], {s_offset{1'b0}}};
                        mem_wdata_q   <= bus.line_wdata[s_beat-1:0];
                        cnt_q         <= '0;
                        mem_write_q   <= 1'b1;
                        state_q       <= WR_BURST;
                    end else if (bus.line_read) begin
                        mem_address_q <= {bus.line_address[31:s_offset], {s_offset{1'b0}}};
                        cnt_q         <= '0;
                        mem_read_q    <= 1'b1;
                        state_q       <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (bus.mem_resp) begin
                        line_rdata_q[s_beat*int'(cnt_q) +: s_beat] <= bus.mem_rdata;
                        cnt_q <= cnt_d;
                        if (last_beat) begin
                            mem_read_q  <= 1'b0;
                            line_resp_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (bus.mem_resp) begin
                        cnt_q <= cnt_d;
                        if (last_beat) begin
                            mem_write_q <= 1'b0;
                            line_resp_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            // present the next beat right after the current one is accepted
                            mem_wdata_q <= wdata_q[s_beat*int'(cnt_d) +: s_beat];
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.line_resp   = line_resp_q;
    assign bus.line_rdata  = line_rdata_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata   = mem_wdata_q;

    // line offset bits never reach the memory port
    logic unused_offset;
    assign unused_offset = &{1'b0, bus.line_address[s_offset-1:0]};

`ifdef LBR_STATS_EN
    logic [31:0] rd_count_q;
    logic [31:0] wr_count_q;
    logic        is_wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
            is_wr_q    <= 1'b0;
        end else begin
            // the IDLE cycle that launches a burst decides its direction
            if (state_q == IDLE) begin
                is_wr_q <= bus.line_write;
            end
            if (state_q == DONE) begin
                if (is_wr_q) begin
                    wr_count_q <= wr_count_q + 32'd1;
                end else begin
                    rd_count_q <= rd_count_q + 32'd1;
                end
            end
        end
    end

    assign bus.rd_count = rd_count_q;
    assign bus.wr_count = wr_count_q;
`else
    assign bus.rd_count = '0;
    assign bus.wr_count = '0;
`endif
endmodule

// File: tb/tb_line_burst_responder.sv
// tb/tb_line_burst_responder.sv - scoreboard bench for line_burst_responder
module tb_line_burst_responder;
    localparam int LW = 256;
    localparam int BW = 64;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    initial forever #5 clk = ~clk;

    line_burst_responder_if bus ();
    line_burst_responder dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        logic          is_rd;
        logic [LW-1:0] line;
        int            at_cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [BW-1:0] rbeat_q[$];
    logic [BW-1:0] wbeat_q[$];
    int            stall_cfg  = 0;
    int            beat_limit = 1000;
    int            resp_given = 0;
    int            rd_cycles  = 0;
    int            wr_cycles  = 0;
    int            n_rd       = 0;
    int            n_wr       = 0;
    logic          spurious   = 1'b0;
    logic [31:0]   exp_addr   = '0;
    logic [LW-1:0] last_line  = '0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // memory model: stall_cfg idle cycles before each beat, at most beat_limit beats
    initial begin
        int wait_ctr;
        wait_ctr      = 0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_resp = 1'b0;
            if (rst || !(bus.mem_read || bus.mem_write)) begin
                wait_ctr   = 0;
                resp_given = 0;
                if (spurious) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                end
            end else begin
                if (bus.mem_read)  rd_cycles++;
                if (bus.mem_write) wr_cycles++;
                if (wait_ctr < stall_cfg) begin
                    wait_ctr++;
                end else if (resp_given < beat_limit) begin
                    wait_ctr = 0;
                    resp_given++;
                    bus.mem_resp = 1'b1;
                    check("mem_address", LW'(bus.mem_address), LW'(exp_addr));
                    if (bus.mem_read) begin
                        bus.mem_rdata = (rbeat_q.size() != 0) ? rbeat_q.pop_front() : '0;
                    end
                    if (bus.mem_write) begin
                        if (wbeat_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL mem_wdata: extra beat %0h required none", bus.mem_wdata);
                        end else begin
                            check("mem_wdata", LW'(bus.mem_wdata), LW'(wbeat_q.pop_front()));
                        end
                    end
                end
            end
        end
    end

    // response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.line_resp === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL line_resp: pulse at cycle %0d required none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_cycle", LW'(cyc), LW'(e.at_cyc));
                    if (e.is_rd) check("line_rdata", bus.line_rdata, e.line);
                end
            end
        end
    end

    task automatic wait_resp(input logic scramble);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (scramble) begin
                bus.line_address = ~bus.line_address;
                bus.line_wdata   = ~bus.line_wdata;
            end
            if (bus.line_resp === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL wait_resp: line_resp 0 required 1 within 200 cycles");
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                           input logic [BW-1:0] b2, input logic [BW-1:0] b3, input int stall);
        exp_t e;
        int   rd0;
        @(negedge clk);
        stall_cfg = stall;
        exp_addr  = {addr[31:5], 5'b0};
        rbeat_q.push_back(b0);
        rbeat_q.push_back(b1);
        rbeat_q.push_back(b2);
        rbeat_q.push_back(b3);
        e.is_rd  = 1'b1;
        e.line   = {b3, b2, b1, b0};
        e.at_cyc = cyc + NB*(stall+1) + 1;
        exp_q.push_back(e);
        rd0 = rd_cycles;
        bus.line_read    = 1'b1;
        bus.line_address = addr;
        wait_resp(1'b0);
        bus.line_read = 1'b0;
        check("rd_mem_read_cycles", LW'(rd_cycles - rd0), LW'(NB*(stall+1)));
        last_line = {b3, b2, b1, b0};
        n_rd++;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [LW-1:0] data, input int stall,
                            input logic also_read, input logic scramble);
        exp_t e;
        int   rd0;
        int   wr0;
        @(negedge clk);
        stall_cfg = stall;
        exp_addr  = {addr[31:5], 5'b0};
        for (int k = 0; k < NB; k++) wbeat_q.push_back(data[BW*k +: BW]);
        e.is_rd  = 1'b0;
        e.line   = '0;
        e.at_cyc = cyc + NB*(stall+1) + 1;
        exp_q.push_back(e);
        rd0 = rd_cycles;
        wr0 = wr_cycles;
        bus.line_write   = 1'b1;
        bus.line_read    = also_read;
        bus.line_address = addr;
        bus.line_wdata   = data;
        wait_resp(scramble);
        bus.line_write = 1'b0;
        bus.line_read  = 1'b0;
        check("wr_mem_write_cycles", LW'(wr_cycles - wr0), LW'(NB*(stall+1)));
        check("wr_no_mem_read", LW'(rd_cycles - rd0), '0);
        check("wr_keeps_rdata", bus.line_rdata, last_line);
        n_wr++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_line_resp"},   LW'(bus.line_resp), '0);
        check({tag, "_line_rdata"},  bus.line_rdata, '0);
        check({tag, "_mem_read"},    LW'(bus.mem_read), '0);
        check({tag, "_mem_write"},   LW'(bus.mem_write), '0);
        check({tag, "_mem_address"}, LW'(bus.mem_address), '0);
        check({tag, "_mem_wdata"},   LW'(bus.mem_wdata), '0);
        check({tag, "_rd_count"},    LW'(bus.rd_count), '0);
        check({tag, "_wr_count"},    LW'(bus.wr_count), '0);
        check({tag, "_state_idle"},  LW'(dut.state_q), '0);
    endtask

    initial begin
        bit got2;
        bus.line_read    = 1'b0;
        bus.line_write   = 1'b0;
        bus.line_address = '0;
        bus.line_wdata   = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        do_read(32'h0000_1234, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0);
        do_write(32'h0000_8040, {64'hD3D3_0303_D3D3_0303, 64'hD2D2_0202_D2D2_0202,
                 64'hD1D1_0101_D1D1_0101, 64'hD0D0_0000_D0D0_0000}, 2, 1'b0, 1'b1);
        do_write(32'hABCD_EF5F, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'hA5A5_5A5A_A5A5_5A5A, 64'h0F0F_F0F0_0F0F_F0F0}, 0, 1'b1, 1'b0);
        do_read(32'hFFFF_FFE7, 64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0002,
                64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0004, 1);

        // spurious memory acknowledges while idle
        @(negedge clk);
        spurious = 1'b1;
        repeat (3) @(negedge clk);
        spurious = 1'b0;
        @(negedge clk);
        check("spurious_rdata", bus.line_rdata, last_line);
        check("spurious_mem_read", LW'(bus.mem_read), '0);
        check("spurious_mem_write", LW'(bus.mem_write), '0);
        do_read(32'h0000_0100, 64'h5555_0000_0000_0000, 64'h5555_1111_0000_0000,
                64'h5555_2222_0000_0000, 64'h5555_3333_0000_0000, 0);

        // reset after two beats of a read
        @(negedge clk);
        beat_limit = 2;
        stall_cfg  = 0;
        exp_addr   = 32'h0000_3300;
        for (int k = 0; k < NB; k++) rbeat_q.push_back(64'h7777_0000_0000_0000 + 64'(k));
        bus.line_read    = 1'b1;
        bus.line_address = 32'h0000_3300;
        got2 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp_given >= 2) begin
                got2 = 1'b1;
                break;
            end
        end
        check("abort_two_beats", LW'(got2), LW'(1));
        @(negedge clk);
        rst = 1'b1;
        bus.line_read = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        rbeat_q.delete();
        exp_q.delete();
        beat_limit = 1000;
        last_line  = '0;
        n_rd = 0;
        n_wr = 0;

        do_read(32'h2000_0010, 64'h1010_1010_1010_1010, 64'h2020_2020_2020_2020,
                64'h3030_3030_3030_3030, 64'h4040_4040_4040_4040, 0);
        do_read(32'h2000_0020, 64'h0000_0000_0000_00A1, 64'h0000_0000_0000_00B2,
                64'h0000_0000_0000_00C3, 64'h0000_0000_0000_00D4, 3);
        do_write(32'h2000_0040, {4{64'h9999_8888_7777_6666}}, 1, 1'b0, 1'b0);
        do_write(32'h2000_0060, {64'h4, 64'h3, 64'h2, 64'h1}, 0, 1'b0, 1'b0);
        do_read(32'h2000_0080, 64'hEEEE_0000_0000_0001, 64'hEEEE_0000_0000_0002,
                64'hEEEE_0000_0000_0003, 64'hEEEE_0000_0000_0004, 0);
        repeat (2) @(negedge clk);

`ifdef LBR_STATS_EN
        check("rd_count", LW'(bus.rd_count), LW'(3));
        check("wr_count", LW'(bus.wr_count), LW'(2));
        force dut.rd_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.rd_count_q;
        do_read(32'h3000_0000, 64'h1, 64'h2, 64'h3, 64'h4, 0);
        repeat (2) @(negedge clk);
        check("rd_count_wrap", LW'(bus.rd_count), '0);
        check("wr_count_hold", LW'(bus.wr_count), LW'(2));
`else
        check("rd_count_tied", LW'(bus.rd_count), '0);
        check("wr_count_tied", LW'(bus.wr_count), '0);
`endif

        check("scoreboard_drained", LW'(exp_q.size()), '0);
        check("wbeats_drained", LW'(wbeat_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
